// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// RV32I load/store width codes and the latched request record.
package dmem_pkg;

    localparam int unsigned XLEN      = 32;
    // Width of the address field in the latched request.
    // A responder built with a different DM_ADDRESS must also change this value.
    localparam int unsigned DM_ADDR_W = 9;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic                 we;
        logic [DM_ADDR_W-1:0] addr;
        logic [XLEN-1:0]      wdata;
        logic [2:0]           func3;
    } dmem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32I loads and stores: byte enables, store lane
// replication, load extraction with sign/zero extension, legality check.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic            we_i,
    input  logic [2:0]      func3_i,
    input  logic [1:0]      lane_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] raw_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] st_word_o,
    output logic [XLEN-1:0] ld_val_o,
    output logic            illegal_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = raw_i[{lane_i, 3'b000} +: 8];
    assign half_sel = lane_i[1] ? raw_i[31:16] : raw_i[15:0];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        be_o      = 4'b0000;
        st_word_o = '0;
        ld_val_o  = '0;
        illegal_o = 1'b1;
        unique case (func3_i)
            F3_B: begin
                illegal_o = 1'b0;
                be_o      = 4'b0001 << lane_i;
                st_word_o = {4{wdata_i[7:0]}};
                ld_val_o  = {{24{byte_sel[7]}}, byte_sel};
            end
            F3_H: begin
                illegal_o = lane_i[0];
                be_o      = lane_i[1] ? 4'b1100 : 4'b0011;
                st_word_o = {2{wdata_i[15:0]}};
                ld_val_o  = {{16{half_sel[15]}}, half_sel};
            end
            F3_W: begin
                illegal_o = (lane_i != 2'b00);
                be_o      = 4'b1111;
                st_word_o = wdata_i;
                ld_val_o  = raw_i;
            end
            // Unsigned widths exist only for loads.
            F3_BU: begin
                illegal_o = we_i;
                ld_val_o  = {24'h0, byte_sel};
            end
            F3_HU: begin
                illegal_o = we_i | lane_i[0];
                ld_val_o  = {16'h0, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-addressable word storage behind a req/ack
// handshake with a configurable number of wait states.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DM_ADDRESS  = DM_ADDR_W,
    parameter int unsigned DATA_W      = XLEN,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [2:0]            func3,
    output logic                  ack,
    output logic [DATA_W-1:0]     rdata,
    output logic                  err,
    output logic                  busy
);

    localparam int unsigned WORDS     = 2 ** (DM_ADDRESS - 2);
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    dmem_req_t               req_q, req_d, cur;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    access;
    logic [DM_ADDRESS-3:0]   word_idx;
    logic [DATA_W-1:0]       raw;
    logic [3:0]              be;
    logic [DATA_W-1:0]       st_word, ld_val;
    logic                    illegal;
    logic [DATA_W-1:0]       mem_q [WORDS];

    // In IDLE the live inputs are the request; afterwards the latched copy is.
    assign cur = (state_q == IDLE)
               ? '{we: we, addr: addr, wdata: wdata, func3: func3}
               : req_q;

    assign word_idx = cur.addr[DM_ADDRESS-1:2];
    assign raw      = mem_q[word_idx];

    dmem_lane_align u_align (
        .we_i      (cur.we),
        .func3_i   (cur.func3),
        .lane_i    (cur.addr[1:0]),
        .wdata_i   (cur.wdata),
        .raw_i     (raw),
        .be_o      (be),
        .st_word_o (st_word),
        .ld_val_o  (ld_val),
        .illegal_o (illegal)
    );

    always_comb begin
        // NOTE: combinational logic uses blocking '='; only clocked state takes '<='.
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        access  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    req_d = cur;
                    if (illegal) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        access  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (access && !cur.we) begin
            rdata_d = ld_val;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: storage is deliberately not reset; gating on reset drops a store caught by reset.
    always_ff @(posedge clk) begin
        if (access && cur.we && reset) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[word_idx][8*b +: 8] <= st_word[8*b +: 8];
            end
        end
    end

    assign ack   = (state_q == RESP);
    assign busy  = (state_q != IDLE);
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: the driver queues expected responses, a negedge monitor
// compares every ack against the queue head (data, err, arrival cycle).
module tb_dmem_responder;
    import dmem_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rd;
        int          cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       req_s, we_s, ack_s, err_s, busy_s;
    logic [1:0][8:0]  addr_s;
    logic [1:0][31:0] wdata_s, rdata_s;
    logic [1:0][2:0]  f3_s;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t q0[$];
    exp_t q1[$];

    // dut index 0: two wait states; dut index 1: no wait states
    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset_n), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
        .wdata(wdata_s[0]), .func3(f3_s[0]), .ack(ack_s[0]), .rdata(rdata_s[0]),
        .err(err_s[0]), .busy(busy_s[0])
    );

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset_n), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
        .wdata(wdata_s[1]), .func3(f3_s[1]), .ack(ack_s[1]), .rdata(rdata_s[1]),
        .err(err_s[1]), .busy(busy_s[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int sel);
        exp_t e;
        if (ack_s[sel]) begin
            if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
                total++;
                bad++;
                $display("FAIL dut%0d unexpected_ack: got ack=1 expected no ack (cycle %0d)", sel, cyc);
            end else begin
                if (sel == 0) e = q0.pop_front();
                else          e = q1.pop_front();
                check($sformatf("dut%0d err", sel), {31'h0, err_s[sel]}, {31'h0, e.err});
                if (e.chk_rd) check($sformatf("dut%0d rdata", sel), rdata_s[sel], e.rdata);
                check($sformatf("dut%0d ack_cycle", sel), 32'(cyc), 32'(e.cyc));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic push(input int sel, input exp_t e);
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    // Drive one request at a negedge once the responder is idle; queue its expectation.
    task automatic issue(input int sel, input logic w, input logic [8:0] a, input logic [31:0] d,
                         input logic [2:0] f, input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        @(negedge clk);
        for (int i = 0; i < 50 && busy_s[sel]; i++) @(negedge clk);
        if (busy_s[sel]) begin
            total++;
            bad++;
            $display("FAIL dut%0d idle_timeout: got busy=1 expected busy=0", sel);
        end
        lat = (exp_err || sel == 1) ? 0 : 2;
        req_s[sel]   = 1'b1;
        we_s[sel]    = w;
        addr_s[sel]  = a;
        wdata_s[sel] = d;
        f3_s[sel]    = f;
        push(sel, '{rdata: exp_rd, err: exp_err, chk_rd: !w || exp_err, cyc: cyc + 1 + lat});
    endtask

    task automatic finish_req(input int sel);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_s[sel] && n < 40);
        if (!ack_s[sel]) begin
            total++;
            bad++;
            $display("FAIL dut%0d ack_timeout: got ack=0 expected ack=1", sel);
        end
        req_s[sel] = 1'b0;
    endtask

    task automatic ld(input int sel, input logic [8:0] a, input logic [2:0] f,
                      input logic [31:0] exp_rd, input logic exp_err);
        issue(sel, 1'b0, a, 32'h0, f, exp_rd, exp_err);
        finish_req(sel);
    endtask

    task automatic st(input int sel, input logic [8:0] a, input logic [31:0] d,
                      input logic [2:0] f, input logic exp_err);
        issue(sel, 1'b1, a, d, f, 32'h0, exp_err);
        finish_req(sel);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        req_s   = '0;
        we_s    = '0;
        addr_s  = '0;
        wdata_s = '0;
        f3_s    = '0;
        #12;
        for (int s = 0; s < 2; s++) begin
            check($sformatf("dut%0d reset_outputs", s),
                  {28'h0, ack_s[s], err_s[s], busy_s[s], 1'b0}, 32'h0);
            check($sformatf("dut%0d reset_rdata", s), rdata_s[s], 32'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        // Word store and load back, then sub-word loads with both extensions.
        st(0, 9'h010, 32'hDEADBEEF, F3_W, 1'b0);
        ld(0, 9'h010, F3_W,  32'hDEADBEEF, 1'b0);
        ld(0, 9'h013, F3_B,  32'hFFFFFFDE, 1'b0);
        ld(0, 9'h013, F3_BU, 32'h000000DE, 1'b0);
        ld(0, 9'h012, F3_H,  32'hFFFFDEAD, 1'b0);
        ld(0, 9'h012, F3_HU, 32'h0000DEAD, 1'b0);
        ld(0, 9'h010, F3_B,  32'hFFFFFFEF, 1'b0);

        // Partial stores touch only their lanes.
        st(0, 9'h011, 32'h00000011, F3_B, 1'b0);
        ld(0, 9'h010, F3_W, 32'hDEAD11EF, 1'b0);
        st(0, 9'h012, 32'h0000CAFE, F3_H, 1'b0);
        ld(0, 9'h010, F3_W, 32'hCAFE11EF, 1'b0);

        // Misaligned and illegal codes respond after one cycle with err.
        ld(0, 9'h011, F3_H,   32'h0, 1'b1);
        ld(0, 9'h012, F3_W,   32'h0, 1'b1);
        ld(0, 9'h010, 3'b011, 32'h0, 1'b1);
        st(0, 9'h010, 32'h0, F3_BU, 1'b1);
        st(0, 9'h012, 32'h0, F3_W,  1'b1);
        ld(0, 9'h010, F3_W, 32'hCAFE11EF, 1'b0);

        // Reset during WAIT drops the pending store and its ack.
        st(0, 9'h020, 32'h00000000, F3_W, 1'b0);
        @(negedge clk);
        req_s[0]   = 1'b1;
        we_s[0]    = 1'b1;
        addr_s[0]  = 9'h020;
        wdata_s[0] = 32'h12345678;
        f3_s[0]    = F3_W;
        @(negedge clk);
        check("busy_in_wait", {31'h0, busy_s[0]}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("busy_after_async_reset", {31'h0, busy_s[0]}, 32'h0);
        check("ack_after_async_reset",  {31'h0, ack_s[0]},  32'h0);
        req_s[0] = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        ld(0, 9'h020, F3_W, 32'h00000000, 1'b0);

        // Zero wait states, req held high across two loads.
        st(1, 9'h040, 32'hA5A5A5A5, F3_W, 1'b0);
        st(1, 9'h044, 32'h0BADF00D, F3_W, 1'b0);
        ld(1, 9'h046, F3_HU, 32'h00000BAD, 1'b0);
        @(negedge clk);
        req_s[1]  = 1'b1;
        we_s[1]   = 1'b0;
        addr_s[1] = 9'h040;
        f3_s[1]   = F3_W;
        push(1, '{rdata: 32'hA5A5A5A5, err: 1'b0, chk_rd: 1'b1, cyc: cyc + 1});
        push(1, '{rdata: 32'h0BADF00D, err: 1'b0, chk_rd: 1'b1, cyc: cyc + 3});
        @(negedge clk);
        addr_s[1] = 9'h044;
        @(negedge clk);
        check("b2b_busy_gap", {31'h0, busy_s[1]}, 32'h0);
        check("b2b_ack_gap",  {31'h0, ack_s[1]},  32'h0);
        @(negedge clk);
        req_s[1] = 1'b0;

        repeat (6) @(negedge clk);
        check("dut0 queue_drained", 32'(q0.size()), 32'h0);
        check("dut1 queue_drained", 32'(q1.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder (memory side) of the core's data-memory bus. Serves the load/store requests the pipeline's MEM stage issues.
- Holds byte-addressable word storage and applies RV32I width and sign rules selected by func3.
- Inserts a configurable number of wait states and answers each request with a one-cycle ack, so the core can later be moved to stall-on-memory operation.

Parameters:
- DM_ADDRESS, 9: byte-address width; storage is 2^(DM_ADDRESS-2) words.
- DATA_W, 32: data width; fixed at 32 for RV32I.
- WAIT_CYCLES, 2: wait states between accept and response; legal range 0..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  request valid. Held high with we/addr/wdata/func3 stable until ack.
- we  in  1  1 = store, 0 = load.
- addr  in  DM_ADDRESS  byte address.
- wdata  in  DATA_W  store data; lanes taken from the LSBs.
- func3  in  3  RV32I width/sign code.
- ack  out  1  one-cycle response strobe.
- rdata  out  DATA_W  load result; valid only while ack=1.
- err  out  1  misaligned access or illegal func3; valid only while ack=1.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0, at any time including mid-transaction): state=IDLE, ack=0, rdata=0, err=0, busy=0, wait counter=0. Any pending store is discarded. Storage contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req=1, latch we, addr, wdata and func3.
  - Check legality:
    - Loads: func3 in {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}.
    - Stores: func3 in {000 SB, 001 SH, 010 SW}.
    - Halfword accesses need addr[0]=0; word accesses need addr[1:0]=0.
  - Illegal: go to RESP with err=1, rdata=0, no storage access.
  - Legal with WAIT_CYCLES=0: go to RESP and perform the access on that same edge.
  - Legal otherwise: go to WAIT with counter=WAIT_CYCLES-1.
- WAIT: decrement the counter each cycle. At 0, go to RESP and perform the access on that edge.
- Access, performed on the edge entering RESP:
  - Stores write only the addressed byte lanes (SB: 1 lane at addr[1:0]; SH: 2 lanes at addr[1]; SW: 4 lanes).
  - Loads register rdata: byte or half lane extracted and shifted to the LSBs; LB/LH sign-extended, LBU/LHU zero-extended.
- RESP: ack=1 for exactly one cycle, then return to IDLE unconditionally. rdata and err hold their values only during ack, and return to 0 in IDLE.
- Latency: ack is high in cycle N+WAIT_CYCLES+1 for a request sampled at edge N. Illegal requests ack in cycle N+1.
- Back-to-back: req still high in the IDLE cycle after RESP is a new request, so maximum throughput is one transaction per WAIT_CYCLES+2 cycles.
- Inputs are ignored outside IDLE. A change on req/addr during WAIT has no effect.
- Address range: addr covers storage exactly, so no out-of-range case exists and wrap-around cannot occur.

Decomposition:
- Shared package dmem_pkg holds:
  - FSM state enum {IDLE, WAIT, RESP}.
  - func3 localparams F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - Struct dmem_req_t {we, addr, wdata, func3} used for the latched request.
- One sub-module, dmem_lane_align (combinational), produces:
  - the 4-bit byte-enable and lane-shifted store word from (func3, addr[1:0], wdata);
  - the extracted and extended load value from (func3, addr[1:0], raw word);
  - the misaligned/illegal flag.

Test Plan:
- SW 0xDEADBEEF @0x010 (WAIT_CYCLES=2), then LW @0x010 -> each ack is 3 cycles after accept; LW rdata=0xDEADBEEF, err=0.
- After the above: LB @0x013 -> 0xFFFFFFDE; LBU @0x013 -> 0x000000DE; LH @0x012 -> 0xFFFFDEAD; LHU @0x012 -> 0x0000DEAD.
- SB wdata=0x00000011 @0x011, then LW @0x010 -> 0xDEAD11EF (only lane 1 changed). SH 0xCAFE @0x012, then LW -> 0xCAFE11EF.
- LH @0x011, LW @0x012 and load func3=3'b011 -> ack 1 cycle after accept, err=1, rdata=0; storage unchanged (LW @0x010 still 0xCAFE11EF).
- @0x020 holds 0; SW 0x12345678 @0x020, reset pulled low during WAIT -> busy=0 and ack=0 immediately, no ack ever issued for that request; after release, LW @0x020 -> 0x00000000.
- WAIT_CYCLES=0, req held high for two LW requests -> ack pulses in cycles 1 and 3, busy low in cycle 2, rdata correct for each.
